task_scheduler: RTL and testbench

TASK_SCHEDULER -- requirements
Module: task_scheduler

---
 rtl/task_scheduler_if.sv | 38 +++
 rtl/task_scheduler.sv | 154 +++++++++++++++
 tb/tb_task_scheduler.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/task_scheduler_if.sv
// Bundle of every non-clock signal between the scheduler, its tasks and the shared memory.
// master: the scheduler side. slave: the tasks / environment side.
interface task_scheduler_if #(
    parameter int unsigned NUM_TASKS = 4,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned WORD_W    = 16
);
    localparam int unsigned IDX_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;

    logic                          run;
    logic [NUM_TASKS-1:0]          task_mask;
    logic [NUM_TASKS-1:0]          task_en;
    logic [NUM_TASKS-1:0]          task_start;
    logic [NUM_TASKS-1:0]          task_done;
    logic [NUM_TASKS*ADDR_W-1:0]   task_addr;
    logic [NUM_TASKS-1:0]          task_wr_en;
    logic [NUM_TASKS*WORD_W-1:0]   task_wdata;
    logic [ADDR_W-1:0]             mem_addr;
    logic                          mem_wr_en;
    logic [WORD_W-1:0]             mem_wdata;
    logic                          busy;
    logic                          round_done;
    logic [IDX_W-1:0]              cur_task;
    logic                          timeout_err;
    logic [IDX_W-1:0]              err_task;

    modport master (
        input  run, task_mask, task_done, task_addr, task_wr_en, task_wdata,
        output task_en, task_start, mem_addr, mem_wr_en, mem_wdata,
        output busy, round_done, cur_task, timeout_err, err_task
    );

    modport slave (
        output run, task_mask, task_done, task_addr, task_wr_en, task_wdata,
        input  task_en, task_start, mem_addr, mem_wr_en, mem_wdata,
        input  busy, round_done, cur_task, timeout_err, err_task
    );
endinterface

// File: rtl/task_scheduler.sv
// Round-robin-free task scheduler: runs each masked task once per round in ascending order,
// granting the shared memory port to the task currently waiting, with a per-task timeout.
module task_scheduler #(
    parameter int unsigned NUM_TASKS = 4,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned TIMEOUT   = 1023
) (
    input logic               clock,
    input logic               rst,
    task_scheduler_if.master  bus
);
    localparam int unsigned IDX_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;
    localparam logic [15:0] TimeoutW = 16'(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StEnable, StStart, StWait, StNext, StFinish} state_e;

    state_e               state_q, state_d;
    logic [NUM_TASKS-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]     cur_task_q, cur_task_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [IDX_W-1:0]     err_task_q, err_task_d;

    logic                 first_found, next_found;
    logic [IDX_W-1:0]     first_idx, next_idx;
    logic [15:0]          cnt_inc;
    logic [NUM_TASKS-1:0] en_vec, start_vec;

    // Lowest set bit of the incoming mask, and lowest latched bit above the current task.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int unsigned i = 0; i < NUM_TASKS; i++) begin
            if (!first_found && bus.task_mask[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
            if (!next_found && mask_q[i] && (i > 32'(cur_task_q))) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
        end
    end

    // Saturating wait counter: counts completed WAIT cycles, never exceeds TIMEOUT.
    assign cnt_inc = (cnt_q >= TimeoutW) ? cnt_q : cnt_q + 16'd1;

    // Next-state and bookkeeping for the scheduling FSM.
    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        cur_task_d    = cur_task_q;
        cnt_d         = cnt_q;
        busy_d        = busy_q;
        timeout_err_d = timeout_err_q;
        err_task_d    = err_task_q;
        case (state_q)
            StIdle: begin
                if (bus.run) begin
                    mask_d        = bus.task_mask;
                    timeout_err_d = 1'b0;
                    busy_d        = 1'b1;
                    if (first_found) begin
                        cur_task_d = first_idx;
                        state_d    = StEnable;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StEnable: state_d = StStart;
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_inc;
                if (bus.task_done[cur_task_q]) begin
                    state_d = StNext;
                end else if (cnt_inc >= TimeoutW) begin
                    // The task used its full allowance of WAIT cycles; abort it.
                    timeout_err_d = 1'b1;
                    err_task_d    = cur_task_q;
                    state_d       = StNext;
                end
            end
            StNext: begin
                if (next_found) begin
                    cur_task_d = next_idx;
                    state_d    = StEnable;
                end else begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; a reset mid-round simply abandons the round.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q       <= StIdle;
            mask_q        <= '0;
            cur_task_q    <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            err_task_q    <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            cur_task_q    <= cur_task_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            err_task_q    <= err_task_d;
        end
    end

    // Decoded pulses and the memory mux; only the waiting task reaches the memory port.
    always_comb begin
        en_vec        = '0;
        start_vec     = '0;
        bus.mem_addr  = '0;
        bus.mem_wr_en = 1'b0;
        bus.mem_wdata = '0;
        case (state_q)
            StEnable: en_vec[cur_task_q] = 1'b1;
            StStart:  start_vec[cur_task_q] = 1'b1;
            StWait: begin
                bus.mem_addr  = bus.task_addr[32'(cur_task_q) * ADDR_W +: ADDR_W];
                bus.mem_wr_en = bus.task_wr_en[cur_task_q];
                bus.mem_wdata = bus.task_wdata[32'(cur_task_q) * WORD_W +: WORD_W];
            end
            default: ;
        endcase
    end

    assign bus.task_en     = en_vec;
    assign bus.task_start  = start_vec;
    assign bus.busy        = busy_q;
    assign bus.round_done  = (state_q == StFinish);
    assign bus.cur_task    = cur_task_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.err_task    = err_task_q;
endmodule

// File: tb/tb_task_scheduler.sv
// Scoreboard bench for task_scheduler: stimulus pushes expected grants and round results,
// a monitor pops and compares them whenever the scheduler pulses task_en/task_start/round_done.
module tb_task_scheduler;
    localparam int unsigned NT = 4;
    localparam int unsigned AW = 11;
    localparam int unsigned WW = 16;
    localparam int unsigned TO = 1023;

    typedef struct {
        int         lat;
        logic       terr;
        logic [1:0] etask;
    } round_t;

    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    task_scheduler_if #(.NUM_TASKS(NT), .ADDR_W(AW), .WORD_W(WW)) bus ();

    task_scheduler #(.NUM_TASKS(NT), .ADDR_W(AW), .WORD_W(WW), .TIMEOUT(TO)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int grant_q[$];
    round_t round_q[$];
    int done_dly[NT];
    int dcnt[NT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_task_en"}, 32'(bus.task_en), 0);
        check({tag, "_task_start"}, 32'(bus.task_start), 0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        check({tag, "_mem_wr_en"}, 32'(bus.mem_wr_en), 0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_round_done"}, 32'(bus.round_done), 0);
        check({tag, "_cur_task"}, 32'(bus.cur_task), 0);
        check({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
        check({tag, "_err_task"}, 32'(bus.err_task), 0);
    endtask

    task automatic check_mem(input string tag, input logic [AW-1:0] a, input logic w,
                             input logic [WW-1:0] d);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(a));
        check({tag, "_mem_wr_en"}, 32'(bus.mem_wr_en), 32'(w));
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(d));
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (bus.busy && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        check("round_finished_busy", 32'(bus.busy), 0);
    endtask

    // Task model: done rises done_dly cycles after the start pulse (0 = never), held until restart.
    initial begin
        bus.task_done = '0;
        for (int k = 0; k < NT; k++) dcnt[k] = 0;
        forever begin
            @(negedge clock);
            for (int k = 0; k < NT; k++) begin
                if (rst) begin
                    dcnt[k] = 0;
                    bus.task_done[k] = 1'b0;
                end else if (bus.task_start[k]) begin
                    bus.task_done[k] = 1'b0;
                    dcnt[k] = done_dly[k];
                end else if (dcnt[k] > 0) begin
                    dcnt[k]--;
                    if (dcnt[k] == 0) bus.task_done[k] = 1'b1;
                end
            end
        end
    end

    // Monitor: pops expected grants on task_en and expected round results on round_done.
    initial begin
        int cyc;
        int t_acc;
        int e;
        logic busy_prev;
        logic [NT-1:0] en_prev;
        logic [NT-1:0] ev;
        round_t r;
        cyc = 0;
        t_acc = 0;
        busy_prev = 1'b0;
        en_prev = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (rst) begin
                en_prev = '0;
                busy_prev = 1'b0;
            end else begin
                if (bus.busy && !busy_prev) t_acc = cyc - 1;
                busy_prev = bus.busy;
                if (bus.task_en != '0) begin
                    if (grant_q.size() == 0) begin
                        check("unexpected_task_en", 32'(bus.task_en), 0);
                    end else begin
                        e = grant_q.pop_front();
                        ev = '0;
                        ev[e] = 1'b1;
                        check("task_en_grant", 32'(bus.task_en), 32'(ev));
                        check("cur_task_grant", 32'(bus.cur_task), 32'(e));
                    end
                end
                if (bus.task_start != '0 || en_prev != '0)
                    check("task_start_follows_en", 32'(bus.task_start), 32'(en_prev));
                en_prev = bus.task_en;
                if (bus.round_done) begin
                    if (round_q.size() == 0) begin
                        check("unexpected_round_done", 32'(bus.round_done), 0);
                    end else begin
                        r = round_q.pop_front();
                        check("round_latency", 32'(cyc - t_acc), 32'(r.lat));
                        check("round_timeout_err", 32'(bus.timeout_err), 32'(r.terr));
                        check("round_err_task", 32'(bus.err_task), 32'(r.etask));
                        check("round_busy", 32'(bus.busy), 1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed rounds with hand-computed grant order and latency.
    initial begin
        rst = 1'b1;
        bus.run = 1'b0;
        bus.task_mask = '0;
        bus.task_addr = {11'h155, 11'h7FF, 11'h688, 11'h002};
        bus.task_wr_en = 4'b1101;
        bus.task_wdata = {16'h5555, 16'hBEEF, 16'h1234, 16'hAAAA};
        for (int k = 0; k < NT; k++) done_dly[k] = 5;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clock);

        // Mask 1011, done 5 cycles after start: 8 cycles per task plus FINISH -> 25.
        grant_q.push_back(0);
        grant_q.push_back(1);
        grant_q.push_back(3);
        round_q.push_back('{lat: 25, terr: 1'b0, etask: 2'd0});
        bus.run = 1'b1;
        bus.task_mask = 4'b1011;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 1) begin
                bus.run = 1'b0;
                bus.task_mask = 4'b1111;
            end
            if (c == 2) check_mem("start0", 11'h000, 1'b0, 16'h0000);
            if (c == 5) check_mem("wait0", 11'h002, 1'b1, 16'hAAAA);
            if (c == 10) check_mem("start1", 11'h000, 1'b0, 16'h0000);
            if (c == 12) check_mem("wait1", 11'h688, 1'b0, 16'h1234);
            if (c == 20) check_mem("wait3", 11'h155, 1'b1, 16'h5555);
        end
        wait_idle(100);
        @(negedge clock);

        // Mask 0100, task 2 never finishes: 1023 WAIT cycles, then NEXT and FINISH -> 1027.
        done_dly[2] = 0;
        grant_q.push_back(2);
        round_q.push_back('{lat: 1027, terr: 1'b1, etask: 2'd2});
        bus.run = 1'b1;
        bus.task_mask = 4'b0100;
        @(negedge clock);
        bus.run = 1'b0;
        wait_idle(1100);
        repeat (3) @(negedge clock);
        check("sticky_timeout_err", 32'(bus.timeout_err), 1);
        check("sticky_err_task", 32'(bus.err_task), 2);

        // Empty mask: round_done one cycle after acceptance; next run clears timeout_err.
        round_q.push_back('{lat: 1, terr: 1'b0, etask: 2'd2});
        bus.run = 1'b1;
        bus.task_mask = 4'b0000;
        @(negedge clock);
        bus.run = 1'b0;
        wait_idle(10);
        @(negedge clock);
        check("cleared_timeout_err", 32'(bus.timeout_err), 0);

        // Second run mid-round is ignored; reset during task 0 WAIT aborts without round_done.
        for (int k = 0; k < NT; k++) done_dly[k] = 5;
        grant_q.push_back(0);
        bus.run = 1'b1;
        bus.task_mask = 4'b0011;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (c == 1) bus.run = 1'b0;
            if (c == 3) bus.run = 1'b1;
            if (c == 4) bus.run = 1'b0;
            if (c == 5) rst = 1'b1;
        end
        check_all_zero("abort");
        rst = 1'b0;
        repeat (30) @(negedge clock);
        check("abort_busy_stays_low", 32'(bus.busy), 0);

        check("grant_queue_drained", 32'(grant_q.size()), 0);
        check("round_queue_drained", 32'(round_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
